// File: rtl/renode_axi_manager_if.sv
// Bundle for renode_axi_manager: local command/data/response streams plus the AXI4 manager
// channels. "master" is the manager's view, "slave" is the engine + subordinate view.
interface renode_axi_manager_if #(
  parameter int unsigned AddressWidth       = 32,
  parameter int unsigned DataWidth          = 64,
  parameter int unsigned TransactionIdWidth = 8
);
  localparam int unsigned StrobeWidth = DataWidth / 8;

  // Local command / data / response streams
  logic                          cmd_valid;
  logic                          cmd_ready;
  logic                          cmd_write;
  logic [AddressWidth-1:0]       cmd_addr;
  logic [7:0]                    cmd_len;
  logic [2:0]                    cmd_size;
  logic [TransactionIdWidth-1:0] cmd_id;
  logic                          wd_valid;
  logic                          wd_ready;
  logic [DataWidth-1:0]          wd_data;
  logic                          rd_valid;
  logic                          rd_ready;
  logic [DataWidth-1:0]          rd_data;
  logic                          rd_last;
  logic                          rsp_valid;
  logic                          rsp_ready;
  logic [1:0]                    rsp_resp;
  logic                          rsp_timeout;

  // AXI4 channels
  logic [TransactionIdWidth-1:0] awid;
  logic [AddressWidth-1:0]       awaddr;
  logic [7:0]                    awlen;
  logic [2:0]                    awsize;
  logic [1:0]                    awburst;
  logic                          awvalid;
  logic                          awready;
  logic [DataWidth-1:0]          wdata;
  logic [StrobeWidth-1:0]        wstrb;
  logic                          wlast;
  logic                          wvalid;
  logic                          wready;
  logic [TransactionIdWidth-1:0] bid;
  logic [1:0]                    bresp;
  logic                          bvalid;
  logic                          bready;
  logic [TransactionIdWidth-1:0] arid;
  logic [AddressWidth-1:0]       araddr;
  logic [7:0]                    arlen;
  logic [2:0]                    arsize;
  logic [1:0]                    arburst;
  logic                          arvalid;
  logic                          arready;
  logic [TransactionIdWidth-1:0] rid;
  logic [DataWidth-1:0]          rdata;
  logic [1:0]                    rresp;
  logic                          rlast;
  logic                          rvalid;
  logic                          rready;

  modport master (
    input  cmd_valid, cmd_write, cmd_addr, cmd_len, cmd_size, cmd_id,
    output cmd_ready,
    input  wd_valid, wd_data,
    output wd_ready,
    output rd_valid, rd_data, rd_last,
    input  rd_ready,
    output rsp_valid, rsp_resp, rsp_timeout,
    input  rsp_ready,
    output awid, awaddr, awlen, awsize, awburst, awvalid,
    input  awready,
    output wdata, wstrb, wlast, wvalid,
    input  wready,
    input  bid, bresp, bvalid,
    output bready,
    output arid, araddr, arlen, arsize, arburst, arvalid,
    input  arready,
    input  rid, rdata, rresp, rlast, rvalid,
    output rready
  );

  modport slave (
    output cmd_valid, cmd_write, cmd_addr, cmd_len, cmd_size, cmd_id,
    input  cmd_ready,
    output wd_valid, wd_data,
    input  wd_ready,
    input  rd_valid, rd_data, rd_last,
    output rd_ready,
    input  rsp_valid, rsp_resp, rsp_timeout,
    output rsp_ready,
    input  awid, awaddr, awlen, awsize, awburst, awvalid,
    output awready,
    input  wdata, wstrb, wlast, wvalid,
    output wready,
    output bid, bresp, bvalid,
    input  bready,
    input  arid, araddr, arlen, arsize, arburst, arvalid,
    output arready,
    output rid, rdata, rresp, rlast, rvalid,
    input  rready
  );
endinterface

// File: rtl/renode_axi_manager.sv
// AXI4 manager: one local command becomes one INCR burst and ends with one response beat.
// Define RENODE_AXI_MANAGER_TIMEOUT_EN to add a per-channel stall watchdog.
module renode_axi_manager #(
  parameter int unsigned AddressWidth       = 32,
  parameter int unsigned DataWidth          = 64,
  parameter int unsigned TransactionIdWidth = 8,
  parameter int unsigned TimeoutCycles      = 1024
) (
  input logic                  aclk,
  input logic                  areset,
  renode_axi_manager_if.master bus
);
  localparam int unsigned StrobeWidth = DataWidth / 8;
  localparam int unsigned OffsetWidth = $clog2(StrobeWidth);
  localparam logic [2:0]  SizeMax     = 3'(OffsetWidth);
  localparam logic [1:0]  RespOkay    = 2'b00;
  localparam logic [1:0]  RespSlvErr  = 2'b10;
  localparam logic [1:0]  BurstIncr   = 2'b01;

  typedef enum logic [2:0] {StIdle, StAw, StW, StB, StAr, StR, StRsp} state_e;

  state_e                        state_q, state_d;
  logic [AddressWidth-1:0]       addr_q, addr_d;
  logic [7:0]                    len_q, len_d;
  logic [2:0]                    size_q, size_d;
  logic [TransactionIdWidth-1:0] id_q, id_d;
  logic [7:0]                    cnt_q, cnt_d;
  logic                          wr_done_q, wr_done_d;
  logic                          wvalid_q, wvalid_d;
  logic [DataWidth-1:0]          wdata_q, wdata_d;
  logic [StrobeWidth-1:0]        wstrb_q, wstrb_d;
  logic                          wlast_q, wlast_d;
  logic [1:0]                    resp_q, resp_d;

  logic                   cmd_fire, wd_fire, aw_fire, w_fire, b_fire, ar_fire, r_fire;
  logic                   cmd_bad;
  logic [StrobeWidth-1:0] beat_strb;
  logic [1:0]             beat_resp;
  int unsigned            beat_off, beat_bytes;

  function automatic logic [1:0] max_resp(input logic [1:0] a, input logic [1:0] b);
    return (a > b) ? a : b;
  endfunction

  assign cmd_fire = bus.cmd_valid && bus.cmd_ready;
  assign wd_fire  = bus.wd_valid && bus.wd_ready;
  assign aw_fire  = bus.awvalid && bus.awready;
  assign w_fire   = bus.wvalid && bus.wready;
  assign b_fire   = bus.bvalid && bus.bready;
  assign ar_fire  = bus.arvalid && bus.arready;
  assign r_fire   = bus.rvalid && bus.rready;

  assign cmd_bad = (bus.cmd_size > SizeMax) ||
                   (|(bus.cmd_addr & ~({AddressWidth{1'b1}} << bus.cmd_size)));

  // Byte lanes of the current beat; addr_q walks the burst once AW has been accepted.
  always_comb begin
    beat_off   = 32'(addr_q[OffsetWidth-1:0]);
    beat_bytes = 32'd1 << size_q;
    beat_strb  = '0;
    for (int unsigned i = 0; i < StrobeWidth; i++) begin
      if (i >= beat_off && i < beat_off + beat_bytes) beat_strb[i] = 1'b1;
    end
  end

  always_comb begin
    beat_resp = bus.rresp;
    if (bus.rid != id_q || (bus.rlast && cnt_q != len_q)) begin
      beat_resp = max_resp(bus.rresp, RespSlvErr);
    end
  end

  // Command side
  assign bus.cmd_ready   = (state_q == StIdle) && !areset;
  assign bus.rsp_valid   = (state_q == StRsp);
  assign bus.rsp_resp    = resp_q;

  // Write path
  assign bus.awvalid     = (state_q == StAw);
  assign bus.awaddr      = addr_q;
  assign bus.awlen       = len_q;
  assign bus.awsize      = size_q;
  assign bus.awburst     = BurstIncr;
  assign bus.awid        = id_q;
  assign bus.wvalid      = wvalid_q && (state_q == StW);
  assign bus.wdata       = wdata_q;
  assign bus.wstrb       = wstrb_q;
  assign bus.wlast       = wlast_q;
  assign bus.wd_ready    = (state_q == StW) && !wr_done_q && (!wvalid_q || bus.wready);
  assign bus.bready      = (state_q == StB);

  // Read path
  assign bus.arvalid     = (state_q == StAr);
  assign bus.araddr      = addr_q;
  assign bus.arlen       = len_q;
  assign bus.arsize      = size_q;
  assign bus.arburst     = BurstIncr;
  assign bus.arid        = id_q;
  assign bus.rd_valid    = (state_q == StR) && bus.rvalid;
  assign bus.rd_data     = bus.rdata;
  assign bus.rd_last     = bus.rlast;
  assign bus.rready      = (state_q == StR) && bus.rd_ready;

`ifdef RENODE_AXI_MANAGER_TIMEOUT_EN
  localparam int unsigned TimerWidth = $clog2(TimeoutCycles + 1);

  logic [TimerWidth-1:0] timer_q, timer_d;
  logic                  timeout_q, timeout_d;
  logic                  timed_state, any_fire, expire;

  assign timed_state = state_q inside {StAw, StW, StB, StAr, StR};
  assign any_fire    = wd_fire || aw_fire || w_fire || b_fire || ar_fire || r_fire;
  assign expire      = timed_state && !any_fire && (timer_q == TimerWidth'(TimeoutCycles - 1));
  assign bus.rsp_timeout = timeout_q;
`else
  assign bus.rsp_timeout = 1'b0;
`endif

  always_comb begin
    state_d   = state_q;
    addr_d    = addr_q;
    len_d     = len_q;
    size_d    = size_q;
    id_d      = id_q;
    cnt_d     = cnt_q;
    wr_done_d = wr_done_q;
    wvalid_d  = wvalid_q;
    wdata_d   = wdata_q;
    wstrb_d   = wstrb_q;
    wlast_d   = wlast_q;
    resp_d    = resp_q;

    unique case (state_q)
      StIdle: begin
        if (cmd_fire) begin
          addr_d    = bus.cmd_addr;
          len_d     = bus.cmd_len;
          size_d    = bus.cmd_size;
          id_d      = bus.cmd_id;
          cnt_d     = '0;
          wr_done_d = 1'b0;
          wvalid_d  = 1'b0;
          wlast_d   = 1'b0;
          resp_d    = RespOkay;
          if (cmd_bad) begin
            resp_d  = RespSlvErr;
            state_d = StRsp;
          end else begin
            state_d = bus.cmd_write ? StAw : StAr;
          end
        end
      end
      StAw: if (aw_fire) state_d = StW;
      StW: begin
        if (w_fire) begin
          wvalid_d = 1'b0;
          if (wlast_q) state_d = StB;
        end
        // Skid slot refill; wd_ready guarantees the slot is free or draining this cycle.
        if (wd_fire) begin
          wvalid_d = 1'b1;
          wdata_d  = bus.wd_data;
          wstrb_d  = beat_strb;
          wlast_d  = (cnt_q == len_q);
          addr_d   = addr_q + (AddressWidth'(1) << size_q);
          cnt_d    = cnt_q + 8'd1;
          if (cnt_q == len_q) wr_done_d = 1'b1;
        end
      end
      StB: begin
        if (b_fire) begin
          resp_d  = (bus.bid != id_q) ? max_resp(bus.bresp, RespSlvErr) : bus.bresp;
          state_d = StRsp;
        end
      end
      StAr: if (ar_fire) state_d = StR;
      StR: begin
        if (r_fire) begin
          resp_d = max_resp(resp_q, beat_resp);
          cnt_d  = cnt_q + 8'd1;
          if (bus.rlast) state_d = StRsp;
        end
      end
      StRsp: if (bus.rsp_ready) state_d = StIdle;
      default: state_d = StIdle;
    endcase

`ifdef RENODE_AXI_MANAGER_TIMEOUT_EN
    timeout_d = cmd_fire ? 1'b0 : timeout_q;
    if (expire) begin
      state_d   = StRsp;
      resp_d    = RespSlvErr;
      wvalid_d  = 1'b0;
      timeout_d = 1'b1;
    end
    timer_d = (!timed_state || any_fire || state_d != state_q) ? '0 : timer_q + 1'b1;
`endif
  end

  always_ff @(posedge aclk or posedge areset) begin
    if (areset) begin
      state_q   <= StIdle;
      addr_q    <= '0;
      len_q     <= '0;
      size_q    <= '0;
      id_q      <= '0;
      cnt_q     <= '0;
      wr_done_q <= 1'b0;
      wvalid_q  <= 1'b0;
      wdata_q   <= '0;
      wstrb_q   <= '0;
      wlast_q   <= 1'b0;
      resp_q    <= RespOkay;
    end else begin
      state_q   <= state_d;
      addr_q    <= addr_d;
      len_q     <= len_d;
      size_q    <= size_d;
      id_q      <= id_d;
      cnt_q     <= cnt_d;
      wr_done_q <= wr_done_d;
      wvalid_q  <= wvalid_d;
      wdata_q   <= wdata_d;
      wstrb_q   <= wstrb_d;
      wlast_q   <= wlast_d;
      resp_q    <= resp_d;
    end
  end

`ifdef RENODE_AXI_MANAGER_TIMEOUT_EN
  always_ff @(posedge aclk or posedge areset) begin
    if (areset) begin
      timer_q   <= '0;
      timeout_q <= 1'b0;
    end else begin
      timer_q   <= timer_d;
      timeout_q <= timeout_d;
    end
  end
`endif

endmodule
